// File: rtl/voice_scheduler_pkg.sv
// Shared encodings for the voice scheduler: datapath phases and allocator FSM states.
package voice_scheduler_pkg;

  localparam int NOTE_W_DEF  = 7;
  localparam int VOICE_W_DEF = 8;

  localparam logic [1:0] PS_LOAD    = 2'd0;
  localparam logic [1:0] PS_COMPUTE = 2'd1;
  localparam logic [1:0] PS_WRITE   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_ISSUE = 2'd2
  } alloc_state_e;

endpackage

// File: rtl/voice_scheduler_pipeline_sequencer.sv
// Free-running LOAD/COMPUTE/WRITE phase counter plus the voice index sweep it drives.
module pipeline_sequencer
  import voice_scheduler_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int VOICE_W    = VOICE_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  output logic [1:0]         o_pipeline_state,
  output logic [VOICE_W-1:0] o_voice_index
);

  logic [1:0]         state_q, state_d;
  logic [VOICE_W-1:0] voice_q, voice_d;

  always_comb begin
    state_d = state_q;
    voice_d = voice_q;
    case (state_q)
      PS_LOAD:    state_d = PS_COMPUTE;
      PS_COMPUTE: state_d = PS_WRITE;
      default: begin
        // WRITE (and the unreachable 3) return to LOAD and advance the voice
        state_d = PS_LOAD;
        voice_d = (voice_q == VOICE_W'(NUM_VOICES-1)) ? '0 : voice_q + VOICE_W'(1);
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= PS_LOAD;
      voice_q <= '0;
    end else begin
      state_q <= state_d;
      voice_q <= voice_d;
    end
  end

  assign o_pipeline_state = state_q;
  assign o_voice_index    = voice_q;

endmodule

// File: rtl/voice_scheduler.sv
// Polyphony controller: allocates DDS voices for MIDI note-on/off and strobes config writes.
module voice_scheduler
  import voice_scheduler_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int VOICE_W    = VOICE_W_DEF,
  parameter int NOTE_W     = NOTE_W_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_on,
  input  logic [NOTE_W-1:0]     i_cmd_note,
  output logic [1:0]            o_pipeline_state,
  output logic [VOICE_W-1:0]    o_voice_index,
  output logic                  o_dds_flag,
  output logic [NOTE_W-1:0]     o_dds_midi_note,
  output logic [VOICE_W-1:0]    o_dds_voice_index,
  output logic [NUM_VOICES-1:0] o_voice_active
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  alloc_state_e fsm_q, fsm_d;

  logic                              on_q;
  logic [NOTE_W-1:0]                 note_q;
  logic [VOICE_W-1:0]                scan_k_q;
  logic                              match_found_q, free_found_q;
  logic [VOICE_W-1:0]                match_idx_q, free_idx_q;
  logic [VOICE_W-1:0]                target_q, steal_ptr_q;
  logic [NUM_VOICES-1:0]             active_q;
  logic [NUM_VOICES-1:0][NOTE_W-1:0] note_tbl_q;
  logic [NOTE_W-1:0]                 dds_note_q;
  logic [VOICE_W-1:0]                dds_voice_q;

  logic               accept, fire, last_slot;
  logic               hit, emp, match_now, free_now, steal_now;
  logic [VOICE_W-1:0] match_idx_now, free_idx_now, alloc_idx;

  pipeline_sequencer #(
    .NUM_VOICES (NUM_VOICES),
    .VOICE_W    (VOICE_W)
  ) u_seq (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .o_pipeline_state (o_pipeline_state),
    .o_voice_index    (o_voice_index)
  );

  // Slot k inspected this cycle, folded with results from earlier slots
  always_comb begin
    hit           = active_q[scan_k_q[IDX_W-1:0]] && (note_tbl_q[scan_k_q[IDX_W-1:0]] == note_q);
    emp           = !active_q[scan_k_q[IDX_W-1:0]];
    match_now     = match_found_q | hit;
    match_idx_now = match_found_q ? match_idx_q : scan_k_q;
    free_now      = free_found_q | emp;
    free_idx_now  = free_found_q ? free_idx_q : scan_k_q;
    steal_now     = !match_now && !free_now;
    alloc_idx     = match_now ? match_idx_now : (free_now ? free_idx_now : steal_ptr_q);
    last_slot     = (scan_k_q == VOICE_W'(NUM_VOICES-1));
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) fsm_q <= ST_IDLE;
    else         fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE:  if (i_cmd_valid) fsm_d = ST_SCAN;
      ST_SCAN:  if (last_slot) fsm_d = on_q ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: if (o_pipeline_state == PS_LOAD) fsm_d = ST_IDLE;
      default:  fsm_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_cmd_ready = (fsm_q == ST_IDLE);
    fire        = (fsm_q == ST_ISSUE) && (o_pipeline_state == PS_LOAD);
  end

  assign accept = i_cmd_valid && o_cmd_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      on_q          <= 1'b0;
      note_q        <= '0;
      scan_k_q      <= '0;
      match_found_q <= 1'b0;
      free_found_q  <= 1'b0;
      match_idx_q   <= '0;
      free_idx_q    <= '0;
      target_q      <= '0;
      steal_ptr_q   <= '0;
      active_q      <= '0;
      note_tbl_q    <= '0;
      dds_note_q    <= '0;
      dds_voice_q   <= '0;
    end else begin
      if (accept) begin
        on_q          <= i_cmd_on;
        note_q        <= i_cmd_note;
        scan_k_q      <= '0;
        match_found_q <= 1'b0;
        free_found_q  <= 1'b0;
        match_idx_q   <= '0;
        free_idx_q    <= '0;
      end
      if (fsm_q == ST_SCAN) begin
        scan_k_q      <= scan_k_q + VOICE_W'(1);
        match_found_q <= match_now;
        match_idx_q   <= match_idx_now;
        free_found_q  <= free_now;
        free_idx_q    <= free_idx_now;
        if (last_slot) begin
          if (on_q) begin
            target_q <= alloc_idx;
            if (steal_now)
              steal_ptr_q <= (steal_ptr_q == VOICE_W'(NUM_VOICES-1)) ? '0
                                                                     : steal_ptr_q + VOICE_W'(1);
          end else if (match_now) begin
            active_q[match_idx_now[IDX_W-1:0]] <= 1'b0;
          end
        end
      end
      if (fire) begin
        active_q[target_q[IDX_W-1:0]]   <= 1'b1;
        note_tbl_q[target_q[IDX_W-1:0]] <= note_q;
        dds_note_q                      <= note_q;
        dds_voice_q                     <= target_q;
      end
    end
  end

  // Strobe cycle shows the fresh target; the registers hold it afterwards
  assign o_dds_flag        = fire;
  assign o_dds_midi_note   = fire ? note_q   : dds_note_q;
  assign o_dds_voice_index = fire ? target_q : dds_voice_q;
  assign o_voice_active    = active_q;

endmodule
